// File: rtl/rs_mds_sched_pkg.sv
// rtl/rs_mds_sched_pkg.sv - shared constants for the Twofish RS key-schedule sequencer
// Holds the RS matrix, the GF(2^8) polynomial, product count and FSM encoding.
package rs_mds_sched_pkg;

  localparam int         RS_NPROD = 32;
  localparam logic [8:0] RS_POLY  = 9'h14D;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // idx is row-major: idx[4:3] = row, idx[2:0] = column
  function automatic logic [7:0] rs_coef(input logic [4:0] idx);
    logic [7:0] c;
    case (idx)
      5'd0:  c = 8'h01; 5'd1:  c = 8'hA4; 5'd2:  c = 8'h55; 5'd3:  c = 8'h87;
      5'd4:  c = 8'h5A; 5'd5:  c = 8'h58; 5'd6:  c = 8'hDB; 5'd7:  c = 8'h9E;
      5'd8:  c = 8'hA4; 5'd9:  c = 8'h56; 5'd10: c = 8'h82; 5'd11: c = 8'hF3;
      5'd12: c = 8'h1E; 5'd13: c = 8'hC6; 5'd14: c = 8'h68; 5'd15: c = 8'hE5;
      5'd16: c = 8'h02; 5'd17: c = 8'hA1; 5'd18: c = 8'hFC; 5'd19: c = 8'hC1;
      5'd20: c = 8'h47; 5'd21: c = 8'hAE; 5'd22: c = 8'h3D; 5'd23: c = 8'h19;
      5'd24: c = 8'hA4; 5'd25: c = 8'h55; 5'd26: c = 8'h87; 5'd27: c = 8'h5A;
      5'd28: c = 8'h58; 5'd29: c = 8'hDB; 5'd30: c = 8'h9E; 5'd31: c = 8'h03;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rs_mds_sched_gf8_mul.sv
// rtl/rs_mds_sched_gf8_mul.sv - combinational GF(2^8) multiplier, y = a*b mod POLY
// Shift-and-add over the bits of b; a is doubled (xtime) each step.
module gf8_mul
  import rs_mds_sched_pkg::*;
#(
  parameter logic [8:0] POLY = RS_POLY
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [7:0] acc;
  logic [7:0] aa;

  always_comb begin
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ POLY[7:0]) : {aa[6:0], 1'b0};
    end
  end

  assign y = acc;

endmodule

// File: rtl/rs_mds_sched.sv
// rtl/rs_mds_sched.sv - sequences one shared GF(2^8) multiplier to compute S = RS * m
// Optional RS_PIPE_MUL_EN registers the multiplier output and adds one drain cycle.
module rs_mds_sched
  import rs_mds_sched_pkg::*;
#(
  parameter int         NPROD = RS_NPROD,
  parameter logic [8:0] POLY  = RS_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] m,
  output logic        busy,
  output logic        done,
  output logic [31:0] s_out
);

  localparam int            KW     = $clog2(NPROD);
  localparam logic [KW-1:0] K_LAST = KW'(NPROD - 1);

  logic [1:0]      state;
  logic [KW-1:0]   k;
  logic [7:0][7:0] m_reg;
  logic [3:0][7:0] acc;
  logic [3:0][7:0] acc_next;

  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic [7:0] mul_y;
  logic [1:0] row;

  logic       add_en;
  logic [1:0] add_row;
  logic [7:0] add_val;
  logic       last;

  assign row   = k[4:3];
  assign mul_a = rs_coef(k);
  assign mul_b = m_reg[k[2:0]];

  gf8_mul #(.POLY(POLY)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

`ifdef RS_PIPE_MUL_EN
  logic [7:0] p_reg;
  logic [1:0] p_row;
  logic       p_valid;
  logic       drain;

  // drain marks the extra RUN cycle that only folds in the final product
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg   <= 8'h00;
      p_row   <= 2'd0;
      p_valid <= 1'b0;
      drain   <= 1'b0;
    end else begin
      p_reg   <= mul_y;
      p_row   <= row;
      p_valid <= (state == ST_RUN) && !drain;
      if (state != ST_RUN) drain <= 1'b0;
      else if (k == K_LAST) drain <= 1'b1;
    end
  end

  assign add_en  = (state == ST_RUN) && p_valid;
  assign add_row = p_row;
  assign add_val = p_reg;
  assign last    = (state == ST_RUN) && drain;
`else
  assign add_en  = (state == ST_RUN);
  assign add_row = row;
  assign add_val = mul_y;
  assign last    = (state == ST_RUN) && (k == K_LAST);
`endif

  always_comb begin
    acc_next = acc;
    if (add_en) acc_next[add_row] = acc[add_row] ^ add_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      m_reg <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s_out <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_reg <= m;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          // k parks at K_LAST during a drain cycle; it never runs past it
          if (k != K_LAST) k <= k + 1'b1;
          if (last) begin
            s_out <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            k     <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_mds_sched.sv
// tb/tb_rs_mds_sched.sv - scoreboard bench for rs_mds_sched
// Expected results are queued at launch and popped when done pulses.
module tb_rs_mds_sched;

`ifdef RS_PIPE_MUL_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] m;
  logic        busy;
  logic        done;
  logic [31:0] s_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  rs_mds_sched dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .s_out (s_out)
  );

  // drive start for acceptance edge; returns at negedge of cycle 1
  task automatic launch(input logic [63:0] mv);
    @(negedge clk);
    m     = mv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m     = {$urandom, $urandom};
  endtask

  // entered at negedge of cycle 1; poke_cyc pulses start mid-run (0 = none)
  task automatic wait_result(input string name, input int poke_cyc);
    int          cyc = 1;
    logic        busy_bad = 1'b0;
    logic [31:0] exp_v;
    while (done !== 1'b1 && cyc < LAT + 20) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      start = (cyc == poke_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_run: busy dropped before done, required high cycles 1..%0d", name, LAT - 1);
    end
    checks++;
    if (cyc !== LAT) begin
      errors++;
      $display("FAIL %s latency: done at cycle %0d, required %0d", name, cyc, LAT);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, required 0", name, busy);
    end
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard: done with empty queue, s_out=%h", name, s_out);
      end else begin
        exp_v = sb.pop_front();
        if (s_out !== exp_v) begin
          errors++;
          $display("FAIL %s s_out: got %h, required %h", name, s_out, exp_v);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    m     = 64'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++;
    if (s_out !== 32'h0) begin errors++; $display("FAIL reset_s_out: got %h, required 0", s_out); end
    rst = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic [63:0] mv, input logic [31:0] exp_v);
    sb.push_back(exp_v);
    launch(mv);
    wait_result(name, 0);
  endtask

  task automatic test_ignored_start();
    int extra = 0;
    sb.push_back(32'h05040502);
    launch(64'h02);
    wait_result("m0_02_poke", 10);
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignored_start: got %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back(32'h55A156A4);
    launch(64'h0100);
    wait_result("b2b_first", 0);
    // wait_result returned one cycle after done; hold start so the first IDLE cycle accepts it
    sb.push_back(32'hF1A3F2A5);
    m     = 64'h0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    m = {$urandom, $urandom};
    wait_result("b2b_second", 0);
  endtask

  task automatic test_rst_mid_run();
    int seen = 0;
    launch(64'h01);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || s_out !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%b s_out=%h done=%b, required 0 00000000 0", busy, s_out, done);
    end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d done pulses, required 0", seen);
    end
    test_vector("after_rst", 64'h01, 32'hA402A401);
  endtask

  initial begin
    test_reset();
    test_vector("m_zero", 64'h0, 32'h00000000);
    test_vector("m0_01", 64'h01, 32'hA402A401);
    test_vector("m1_01", 64'h0100, 32'h55A156A4);
    test_vector("m0m1_01", 64'h0101, 32'hF1A3F2A5);
    test_vector("m7_01", 64'h01 << 56, 32'h0319E59E);
    test_ignored_start();
    test_back_to_back();
    test_rst_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_mds_sched.md
Name: rs_mds_sched

Overview:
- Sequences a single shared combinational GF(2^8) multiplier to compute the Twofish key-schedule RS product S = RS · m.
- RS is the fixed 4x8 matrix; m is 8 key bytes; arithmetic is over GF(2^8) with polynomial 0x14D.
- 32 byte products are issued one per cycle and XOR-accumulated into 4 result bytes.
- Sits between key-schedule control and the S-box key word register; trades area (one multiplier) for 32+ cycle latency.

Parameters:
- NPROD, 32, number of products (4 rows x 8 columns); fixed, present for counter sizing only.
- POLY, 9'h14D, GF(2^8) reduction polynomial passed to the multiplier sub-module.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- m  in  64  key bytes; m0 = m[7:0] … m7 = m[63:56]; latched on accepted start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; s_out valid from this cycle.
- s_out  out  32  result; S0 = s_out[7:0] … S3 = s_out[31:24]; held until next accepted start.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. Reset values: busy=0, done=0, s_out=0, counter=0, state=IDLE.
- States:
  - IDLE: start=1 latches m into an internal register, clears the accumulators, sets counter k=0, and moves to RUN.
  - RUN: each cycle the multiplier gets a=RS[r][c] and b=m_reg[c], with r=k[4:3] and c=k[2:0] (row-major). The accumulator does acc[r] ^= y. k increments each cycle. At k=31, after accumulation, move to DONE.
  - DONE: s_out <= acc, done=1 for exactly one cycle, busy=0, then return to IDLE.
- Latency: start accepted at cycle 0; done=1 at cycle 33 (32 RUN cycles plus the DONE cycle).
- Earliest next start: sampled in the cycle after DONE.
- start while busy or in DONE: ignored; not queued.
- Input changes: m changes after acceptance have no effect.
- rst mid-RUN: returns to IDLE, clears s_out and accumulators, and emits no done.
- Counter: 5 bits; wraps only via the state transition and is never observed beyond 31.
- RS constants (row-major):
  - Row 0: 01 A4 55 87 5A 58 DB 9E
  - Row 1: A4 56 82 F3 1E C6 68 E5
  - Row 2: 02 A1 FC C1 47 AE 3D 19
  - Row 3: A4 55 87 5A 58 DB 9E 03
- The multiplier is the only GF arithmetic; accumulation is plain XOR.

Optional Feature:
- Macro RS_PIPE_MUL_EN.
- Defined: a register sits on the multiplier output, and the accumulate uses the product issued in the previous cycle. RUN lasts 33 cycles (one drain cycle with no issue), so done arrives at cycle 34. All results are identical.
- Undefined: purely combinational multiply-accumulate; done at cycle 33.

Decomposition:
- Shared package: the RS constant array, the POLY constant, state encoding (IDLE/RUN/DONE), and NPROD.
- One natural sub-module: gf8_mul (combinational a*b mod POLY, ports a, b, y), instantiated once.
- FSM, counter and accumulator stay in rs_mds_sched.

Test Plan:
- m=0, start pulse -> done at cycle 33, s_out=32'h00000000, busy high during cycles 1..32.
- m0=01, others 0 -> s_out=32'hA402A401 (S0=01, S1=A4, S2=02, S3=A4).
- m1=01, others 0 -> S={A4,56,A1,55}, i.e. s_out=32'h55A156A4. Then m0=m1=01 -> s_out=32'hF1A3F2A5.
- m0=02, others 0 -> S={02,05,04,05} (checks 0x14D reduction). Additionally, pulse start at cycle 10 of this run -> ignored, still a single done.
- Assert rst at cycle 15 of a run with m0=01 -> busy=0 and s_out=0 the next cycle, with no done pulse. A fresh start then gives the normal result.
- With RS_PIPE_MUL_EN defined, repeat the m0=01 case -> done at cycle 34, s_out=32'hA402A401.
